pc_control: RTL and testbench

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pc_control.sv | 119 +++++++++++
 tb/tb_pc_control.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Program counter with a circular call/return stack and sticky overflow/underflow flags.
// Build option: define PC_CONTROL_OVERFLOW_TRAP_EN to vector to TRAP_ADDR on a push into a full stack.
module pc_control #(
  parameter int PROGRAM_ADDR_WIDTH = 10,
  parameter int CALL_DEPTH         = 8,
  parameter int RESET_ADDR         = 0,
  parameter int TRAP_ADDR          = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          advance,
  input  logic                          jump,
  input  logic                          branch,
  input  logic                          call,
  input  logic                          ret,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] target,
  input  logic [PROGRAM_ADDR_WIDTH-1:0] offset,
  input  logic                          clear_flags,
  output logic [PROGRAM_ADDR_WIDTH-1:0] pc,
  output logic [$clog2(CALL_DEPTH):0]   stack_depth,
  output logic                          overflow_flag,
  output logic                          underflow_flag
);

  localparam int PA = PROGRAM_ADDR_WIDTH;
  localparam int PW = $clog2(CALL_DEPTH);
  localparam int DW = PW + 1;
  localparam logic [DW-1:0] FULL      = DW'(CALL_DEPTH);
  localparam logic [PA-1:0] RESET_PC  = PA'(RESET_ADDR);
  localparam logic [PA-1:0] TRAP_PC   = PA'(TRAP_ADDR);
`ifdef PC_CONTROL_OVERFLOW_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [PA-1:0] stack_q [CALL_DEPTH];
  logic [PA-1:0] pc_q, pc_d, pc_inc;
  logic [PW-1:0] sp_q, sp_d, sp_dec;
  logic [DW-1:0] depth_q, depth_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push_en, ovf_set, unf_set;

  assign pc_inc = pc_q + PA'(1);
  assign sp_dec = sp_q - PW'(1);

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    depth_d = depth_q;
    push_en = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (advance) begin
      if (ret) begin
        if (depth_q == '0) begin
          pc_d    = pc_inc;
          unf_set = 1'b1;
        end else begin
          pc_d    = stack_q[sp_dec];
          sp_d    = sp_dec;
          depth_d = depth_q - DW'(1);
        end
      end else if (jump) begin
        pc_d = target;
        if (call) begin
          if (depth_q == FULL) begin
            ovf_set = 1'b1;
            if (TRAP_EN) begin
              pc_d = TRAP_PC;
            end else begin
              // Full circular stack: sp_q points at the oldest entry, so this overwrites it.
              push_en = 1'b1;
              sp_d    = sp_q + PW'(1);
            end
          end else begin
            push_en = 1'b1;
            sp_d    = sp_q + PW'(1);
            depth_d = depth_q + DW'(1);
          end
        end
      end else if (branch) begin
        pc_d = pc_q + offset;
      end else begin
        pc_d = pc_inc;
      end
    end
    // A flag-setting event outranks a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~clear_flags);
    unf_d = unf_set | (unf_q & ~clear_flags);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries are only meaningful below depth_q, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[sp_q] <= pc_inc;
  end

  assign pc             = pc_q;
  assign stack_depth    = depth_q;
  assign overflow_flag  = ovf_q;
  assign underflow_flag = unf_q;

endmodule

// File: tb/tb_pc_control.sv
// Bench for pc_control: directed vector table, overflow/reset sequences, and a
// randomized run against a queue-based reference model.
module tb_pc_control;
  localparam int PA    = 10;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << PA) - 1;
  localparam int TRAP  = 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          advance, jump, branch, call, ret, clear_flags;
  logic [PA-1:0] target, offset;
  logic [PA-1:0] pc;
  logic [3:0]    stack_depth;
  logic          overflow_flag, underflow_flag;

  int checks = 0;
  int errors = 0;

  pc_control dut (
    .clk(clk), .reset_n(reset_n), .advance(advance), .jump(jump), .branch(branch),
    .call(call), .ret(ret), .target(target), .offset(offset), .clear_flags(clear_flags),
    .pc(pc), .stack_depth(stack_depth), .overflow_flag(overflow_flag),
    .underflow_flag(underflow_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit adv, jmp, br, cl, rt, clr;
    int tgt, off;
    int pc, dep;
    bit ovf, unf;
  } vec_t;
  vec_t vt[$];

  // reference model state
  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf;

  task automatic add(input bit a, j, b, c, r, cl, input int t, o, p, d, input bit ov, un);
    vec_t v;
    v.adv = a; v.jmp = j; v.br = b; v.cl = c; v.rt = r; v.clr = cl;
    v.tgt = t; v.off = o; v.pc = p; v.dep = d; v.ovf = ov; v.unf = un;
    vt.push_back(v);
  endtask

  task automatic drive(input bit a, j, b, c, r, cl, input int t, o);
    advance = a; jump = j; branch = b; call = c; ret = r; clear_flags = cl;
    target = PA'(t); offset = PA'(o);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int p, input int d, input bit ov, input bit un);
    chk({tag, ".pc"}, int'(pc), p);
    chk({tag, ".depth"}, int'(stack_depth), d);
    chk({tag, ".ovf"}, int'(overflow_flag), int'(ov));
    chk({tag, ".unf"}, int'(underflow_flag), int'(un));
  endtask

  task automatic model_step(input bit a, j, b, c, r, cl, input int t, o);
    bit so, su;
    int ret_addr;
    so = 0; su = 0;
    ret_addr = (m_pc + 1) & MASK;
    if (a) begin
      if (r) begin
        if (m_q.size() == 0) begin
          m_pc = ret_addr; su = 1;
        end else begin
          m_pc = m_q.pop_back();
        end
      end else if (j) begin
        if (c && m_q.size() == DEPTH) begin
          so = 1;
`ifdef PC_CONTROL_OVERFLOW_TRAP_EN
          m_pc = TRAP;
`else
          void'(m_q.pop_front());
          m_q.push_back(ret_addr);
          m_pc = t & MASK;
`endif
        end else begin
          if (c) m_q.push_back(ret_addr);
          m_pc = t & MASK;
        end
      end else if (b) begin
        m_pc = (m_pc + o) & MASK;
      end else begin
        m_pc = ret_addr;
      end
    end
    m_ovf = so | (m_ovf & !cl);
    m_unf = su | (m_unf & !cl);
  endtask

  initial begin
    int tg[9];
    int exp_ret[8];
    int last;

    reset_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk_all("reset", 0, 0, 0, 0);
    reset_n = 1'b1;

    //    adv j b c r clr  tgt    off    pc     dep ovf unf
    add(1, 0, 0, 0, 0, 0, 0,     0,     1,     0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,     0,     2,     0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,     0,     3,     0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0,     'h3FE, 1,     0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 5,     0,     5,     0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 'h40, 0, 5, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 'h40,  0,     'h40,  0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 'h3FE, 0,     'h3FE, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 0,     4,     'h002, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 'h10,  'h100, 'h10,  0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 'h80,  0,     'h80,  1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,     0,     'h11,  0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,     0,     'h12,  0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0,     0,     'h12,  0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0,     0,     'h13,  0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0,     0,     'h13,  0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 'h100, 0,     'h100, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 'h200, 0,     'h200, 2, 0, 0);
    add(1, 1, 0, 1, 1, 0, 'h300, 0,     'h101, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0,     0,     'h14,  0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 'h300, 0,     'h15,  0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,     0,     'h15,  0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].adv, vt[i].jmp, vt[i].br, vt[i].cl, vt[i].rt, vt[i].clr, vt[i].tgt, vt[i].off);
      step();
      chk_all($sformatf("vec%0d", i), vt[i].pc, vt[i].dep, vt[i].ovf, vt[i].unf);
    end

    // Nine nested calls from pc=0x15 into an eight-entry stack.
    for (int i = 0; i < 9; i++) tg[i] = 'h200 + 'h10 * i;
    for (int i = 0; i < 9; i++) begin
      drive(1, 1, 0, 1, 0, 0, tg[i], 0);
      step();
      if (i < 8) chk_all($sformatf("call%0d", i), tg[i], i + 1, 0, 0);
    end
`ifdef PC_CONTROL_OVERFLOW_TRAP_EN
    chk_all("ovf9", TRAP, 8, 1, 0);
    for (int k = 0; k < 7; k++) exp_ret[k] = tg[6 - k] + 1;
    exp_ret[7] = 'h16;
`else
    chk_all("ovf9", tg[8], 8, 1, 0);
    for (int k = 0; k < 8; k++) exp_ret[k] = tg[7 - k] + 1;
`endif
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 0, 0, 1, 0, 0, 0);
      step();
      chk_all($sformatf("ret%0d", k), exp_ret[k], 7 - k, 1, 0);
    end
    last = exp_ret[7];
    step();
    chk_all("ret_empty", (last + 1) & MASK, 0, 1, 1);

    // Reset asserted between edges while a call is being requested.
    drive(1, 1, 0, 1, 0, 0, 'h50, 0);
    step();
    chk_all("pre_rst", 'h50, 1, 1, 1);
    drive(1, 1, 0, 1, 0, 0, 'h60, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0);
    step();
    chk_all("rst_hold", 0, 0, 0, 0);
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    step();
    chk_all("rst_noleft", 1, 0, 0, 1);

    // Randomized run against the reference model.
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0;
    for (int n = 0; n < 600; n++) begin
      bit a, j, b, c, r, cl;
      int t, o;
      a  = ($urandom % 4) != 0;
      j  = ($urandom % 3) == 0;
      b  = ($urandom % 3) == 0;
      c  = ($urandom % 2) == 0;
      r  = ($urandom % 5) == 0;
      cl = ($urandom % 10) == 0;
      t  = int'($urandom_range(MASK, 0));
      o  = int'($urandom_range(MASK, 0));
      drive(a, j, b, c, r, cl, t, o);
      model_step(a, j, b, c, r, cl, t, o);
      step();
      chk_all($sformatf("rnd%0d", n), m_pc, m_q.size(), m_ovf, m_unf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
